// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver. It latches a 32-bit result word and
// applies it only at frame boundaries. Each digit slot opens with an all-off blank interval.
module seg_scan_driver #(
  parameter int DIGITS       = 8,
  parameter int REFRESH_DIV  = 12500,
  parameter int BLANK_CYCLES = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value_in,
  input  logic        value_valid,
  input  logic        blank_lz,
  output logic [7:0]  seg,
  output logic [6:0]  display,
  output logic        frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [31:0] DIGIT_MASK =
    (DIGITS >= 8) ? 32'hFFFF_FFFF : ((32'h1 << (4 * DIGITS)) - 32'h1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      pending_q, pending_d;
  logic             pend_flag_q, pend_flag_d;
  logic [31:0]      shown_q, shown_d;
  logic             lz_shown_q, lz_shown_d;
  logic [7:0]       seg_q, seg_d;
  logic [6:0]       display_q, display_d;
  logic             frame_done_q, frame_done_d;

  logic             wrap;
  logic             boundary;
  logic             in_blank;
  logic             lz_blank;
  logic [31:0]      upper;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0:    seg_decode = 7'b1000000;
      4'h1:    seg_decode = 7'b1111001;
      4'h2:    seg_decode = 7'b0100100;
      4'h3:    seg_decode = 7'b0110000;
      4'h4:    seg_decode = 7'b0011001;
      4'h5:    seg_decode = 7'b0010010;
      4'h6:    seg_decode = 7'b0000010;
      4'h7:    seg_decode = 7'b1111000;
      4'h8:    seg_decode = 7'b0000000;
      4'h9:    seg_decode = 7'b0010000;
      4'hA:    seg_decode = 7'b0001000;
      4'hB:    seg_decode = 7'b0000011;
      4'hC:    seg_decode = 7'b1000110;
      4'hD:    seg_decode = 7'b0100001;
      4'hE:    seg_decode = 7'b0000110;
      default: seg_decode = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    wrap         = (cnt_q == CNT_LAST);
    boundary     = wrap && (idx_q == IDX_LAST);

    cnt_d        = wrap ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    if (wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    pending_d    = pending_q;
    pend_flag_d  = pend_flag_q;
    shown_d      = shown_q;
    lz_shown_d   = lz_shown_q;
    if (value_valid) pending_d = value_in;
    if (boundary) begin
      // A strobe landing on the boundary goes straight to the display.
      shown_d     = value_valid ? value_in : (pend_flag_q ? pending_q : shown_q);
      lz_shown_d  = blank_lz;
      pend_flag_d = 1'b0;
    end else if (value_valid) begin
      pend_flag_d = 1'b1;
    end

    in_blank     = (BLANK_CYCLES > 0) && (cnt_q < BLANK_END);
    upper        = (shown_q & DIGIT_MASK) >> {idx_q, 2'b00};
    lz_blank     = lz_shown_q && (idx_q != '0) && (upper == 32'h0);

    seg_d        = in_blank ? 8'hFF : ~(8'h01 << idx_q);
    display_d    = (in_blank || lz_blank) ? 7'h7F : seg_decode(upper[3:0]);
    frame_done_d = boundary;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pending_q    <= 32'h0;
      pend_flag_q  <= 1'b0;
      shown_q      <= 32'h0;
      lz_shown_q   <= 1'b0;
      seg_q        <= 8'hFF;
      display_q    <= 7'h7F;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      pend_flag_q  <= pend_flag_d;
      shown_q      <= shown_d;
      lz_shown_q   <= lz_shown_d;
      seg_q        <= seg_d;
      display_q    <= display_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign display    = display_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Multiplexed seven-segment display driver that sits directly downstream of the processor core's 32-bit result bus on the 25 MHz core clock. It latches a result word, time-multiplexes up to eight hex digits onto the shared cathode bus with per-digit anode strobing, inserts anti-ghosting blank intervals, and updates the shown value only at frame boundaries so no digit tears. It replaces the single-digit combinational decode at the top level.

## Interface
- DIGITS, 8, number of scanned digits, 1..8; anodes at or above DIGITS are held at 1.
- REFRESH_DIV, 12500, clock cycles per digit slot (2 kHz slot rate, 250 Hz frame rate at 25 MHz); minimum 2.
- BLANK_CYCLES, 250, cycles at the start of each slot with all anodes off; must satisfy 0 ≤ BLANK_CYCLES < REFRESH_DIV.

- clk  in  1  single clock (25 MHz core clock).
- rst  in  1  asynchronous, active-low reset.
- value_in  in  32  result word from the core; nibble k is shown on digit k.
- value_valid  in  1  single-cycle strobe: capture value_in.
- blank_lz  in  1  1 = blank leading-zero digits.
- seg  out  8  anode enables, active low; seg[k] = 0 selects digit k.
- display  out  7  cathodes {g,f,e,d,c,b,a}, active low.
- frame_done  out  1  one-cycle pulse at each frame boundary.

## Operation
- State: slot counter cnt (0..REFRESH_DIV-1), digit index idx (0..DIGITS-1), pending[31:0], pend_flag, shown[31:0], lz_shown.
- cnt increments every cycle and wraps to 0 at REFRESH_DIV-1; on that wrap idx increments modulo DIGITS.
- Capture: value_valid=1 loads pending ← value_in and sets pend_flag. The last strobe in a frame wins.
- Frame boundary is the cycle where cnt wraps with idx = DIGITS-1. On it: shown ← value_valid ? value_in : (pend_flag ? pending : shown); lz_shown ← blank_lz; pend_flag ← 0, unless value_valid is high, in which case it is consumed directly and pend_flag stays 0.
- Anode: seg = 8'hFF while cnt < BLANK_CYCLES, else seg = ~(1 << idx).
- Cathode: the nibble n = shown[4*idx +: 4] is decoded, active low, as follows:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- During the blank interval, display = 7'h7F.
- Leading-zero blanking: with lz_shown=1, digit idx > 0 shows 7'h7F when every nibble from idx to DIGITS-1 is zero. The anode is still strobed. Digit 0 is never blanked, so shown=0 displays "0".
- seg, display and frame_done are registered; there are no combinational paths from inputs to outputs.

## Timing
- Reset (rst=0, asynchronous): seg=8'hFF, display=7'h7F, frame_done=0, cnt=0, idx=0, shown=0, pending=0, pend_flag=0, lz_shown=0.
- Reset release: the first rising edge with rst=1 advances cnt 0→1. Outputs lag internal cnt/idx by exactly one cycle.
- Reset asserted mid-frame forces all outputs to their reset values immediately, with no clock needed. A pending value is discarded.
- frame_done goes high in the cycle after the boundary cycle, for exactly one cycle. The new shown value appears on digit 0 at the end of that slot's blank interval.
- value_in to visible latency: worst case one full frame (DIGITS·REFRESH_DIV cycles) plus BLANK_CYCLES plus 1.
- value_valid asserted every cycle: shown takes the value present in the boundary cycle.
- BLANK_CYCLES=0: no blank interval; anodes switch directly between adjacent digits.
- DIGITS=1: idx is constant 0, every slot wrap is a frame boundary, and seg alternates between 8'hFF and 8'hFE.

## Test plan
Bench parameters: DIGITS=8, REFRESH_DIV=4, BLANK_CYCLES=1.

- **Reset values:** hold rst=0 for 3 cycles, toggle value_valid → seg=8'hFF, display=7'h7F, frame_done=0 throughout.
- **Basic scan:** value_in=32'h89AB_CDEF with one valid strobe, run 2 frames (64 cycles). In the second frame, each digit k shows 1 blank cycle, then 3 cycles with seg=~(1<<k). Digit 0 shows F=0001110 and digit 7 shows 8=0000000.
- **Tear-free update:** strobe 32'h0000_0001 during digit 3 of a frame → the current frame finishes with the old value; the new value first appears after the next frame_done pulse. Two strobes in one frame → only the second is shown.
- **Leading-zero blanking:** blank_lz=1, value 32'h0000_0050 → digits 2..7 show 7'h7F and digits 1/0 show 5/0. Value 0 → only digit 0 lit, showing 1000000.
- **Boundary collision:** value_valid with 32'h1234_5678 in the exact boundary cycle → shown=32'h1234_5678 in the next frame, pend_flag=0, and no stale pending value reappears.
- **Mid-frame reset:** assert rst=0 during digit 5 with a value pending → outputs go to 8'hFF/7'h7F asynchronously. After release, shown=0 and digit 0 displays 1000000.
